// File: rtl/conv_host_if.sv
// Engine-side bus of the convolution host memory.
//
// Carries the start handshake (ready/busy), the image read port
// (iaddr/idata) and the layer memory access port (cwr/crd/csel with
// their addresses and data).
//   slave  : host side (conv_host_mem) - drives ready, idata, cdata_rd
//   master : engine side - drives busy, addresses, strobes, write data
interface conv_host_if #(
    parameter int DW = 20,
    parameter int AW = 12
);
    logic          ready;
    logic          busy;
    logic [AW-1:0] iaddr;
    logic [DW-1:0] idata;
    logic          cwr;
    logic [AW-1:0] caddr_wr;
    logic [DW-1:0] cdata_wr;
    logic          crd;
    logic [AW-1:0] caddr_rd;
    logic [DW-1:0] cdata_rd;
    logic [2:0]    csel;

    modport slave (
        output ready, idata, cdata_rd,
        input  busy, iaddr, cwr, caddr_wr, cdata_wr, crd, caddr_rd, csel
    );

    modport master (
        input  ready, idata, cdata_rd,
        output busy, iaddr, cwr, caddr_wr, cdata_wr, crd, caddr_rd, csel
    );
endinterface

// File: rtl/conv_host_mem.sv
// Host-side responder for the convolution engine.
//
// Holds the image ROM (loaded through img_*), the layer-0 and layer-1
// result memories, runs the ready/busy start handshake and records
// sticky error flags plus per-run write counts. After a run the results
// can be read back through the registered dump port.
//
// Ports:
//   clk, reset            clock, synchronous active-high reset
//   eng (slave)           engine bus: ready/busy, iaddr/idata,
//                         cwr/crd/csel with layer addresses and data
//   start                 pulse: arm one engine run (IDLE/FIN only)
//   img_we/waddr/wdata    image load port (IDLE/FIN only)
//   dump_req/sel/addr     dump read request (sel 0 = L0, 1 = L1)
//   dump_data/dump_valid  registered dump result, valid one cycle later
//   done                  run completed, sticky until next start
//   err[3:0]              sticky: bad csel, L1 range, ready timeout,
//                         image/dump access while a run is active
//   l0_wr_cnt/l1_wr_cnt   saturating layer write counts for this run
module conv_host_mem #(
    parameter int DW          = 20,
    parameter int AW          = 12,
    parameter int L0_DEPTH    = 4096,
    parameter int L1_DEPTH    = 1024,
    parameter int RDY_TIMEOUT = 16
) (
    input  logic          clk,
    input  logic          reset,
    conv_host_if.slave    eng,
    input  logic          start,
    input  logic          img_we,
    input  logic [AW-1:0] img_waddr,
    input  logic [DW-1:0] img_wdata,
    input  logic          dump_req,
    input  logic          dump_sel,
    input  logic [AW-1:0] dump_addr,
    output logic [DW-1:0] dump_data,
    output logic          dump_valid,
    output logic          done,
    output logic [3:0]    err,
    output logic [12:0]   l0_wr_cnt,
    output logic [10:0]   l1_wr_cnt
);

    localparam int IMG_DEPTH = 1 << AW;
    localparam int L1_AW     = $clog2(L1_DEPTH);
    localparam int TW        = $clog2(RDY_TIMEOUT + 1);

    localparam logic [2:0]    SEL_L0     = 3'b001;
    localparam logic [2:0]    SEL_L1     = 3'b011;
    localparam logic [AW:0]   L1_LIMIT   = (AW + 1)'(L1_DEPTH);
    localparam logic [TW-1:0] TIMER_LAST = TW'(RDY_TIMEOUT - 1);

    typedef enum logic [1:0] {
        IDLE,
        ARM,
        RUN,
        FIN
    } state_t;

    state_t state;
    state_t state_n;

    logic [DW-1:0] img_mem [IMG_DEPTH];
    logic [DW-1:0] l0_mem  [L0_DEPTH];
    logic [DW-1:0] l1_mem  [L1_DEPTH];

    logic          busy_d;
    logic [TW-1:0] timer;

    // FSM-derived events
    logic host_open;     // IDLE or FIN: loader/checker owns the memories
    logic start_run;
    logic timeout_hit;
    logic run_end;

    // access decode
    logic wr_in_l1;
    logic rd_in_l1;
    logic dump_in_l1;
    logic wr_l0;
    logic wr_l1;
    logic img_wr_ok;
    logic dump_ok;
    logic [3:0]    err_set;
    logic [DW-1:0] dump_word;

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        state_n     = state;
        start_run   = 1'b0;
        timeout_hit = 1'b0;
        run_end     = 1'b0;
        host_open   = 1'b0;
        case (state)
            IDLE, FIN: begin
                host_open = 1'b1;
                if (start) begin
                    state_n   = ARM;
                    start_run = 1'b1;
                end
            end
            ARM: begin
                // busy wins over a timeout landing on the same cycle
                if (eng.busy) begin
                    state_n = RUN;
                end else if (timer == TIMER_LAST) begin
                    state_n     = FIN;
                    timeout_hit = 1'b1;
                end
            end
            RUN: begin
                // falling edge of busy ends the run; start is ignored here
                if (busy_d && !eng.busy) begin
                    state_n = FIN;
                    run_end = 1'b1;
                end
            end
            default: state_n = IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // Access decode and error detection
    // ------------------------------------------------------------------
    always_comb begin
        wr_in_l1   = ({1'b0, eng.caddr_wr} < L1_LIMIT);
        rd_in_l1   = ({1'b0, eng.caddr_rd} < L1_LIMIT);
        dump_in_l1 = ({1'b0, dump_addr} < L1_LIMIT);

        wr_l0 = eng.cwr && (eng.csel == SEL_L0);
        wr_l1 = eng.cwr && (eng.csel == SEL_L1) && wr_in_l1;

        // ARM counts as active too: the engine may already be waking up,
        // so the loader must not touch the image or dump port there.
        img_wr_ok = host_open && img_we;
        dump_ok   = host_open && dump_req;

        err_set    = 4'b0000;
        err_set[0] = (eng.cwr || eng.crd)
                     && (eng.csel != SEL_L0) && (eng.csel != SEL_L1);
        err_set[1] = (eng.csel == SEL_L1)
                     && ((eng.cwr && !wr_in_l1) || (eng.crd && !rd_in_l1));
        err_set[2] = timeout_hit;
        err_set[3] = !host_open && (img_we || dump_req);
    end

    // ------------------------------------------------------------------
    // Combinational read ports (read-before-write against this edge)
    // ------------------------------------------------------------------
    assign eng.idata = img_mem[eng.iaddr];

    always_comb begin
        eng.cdata_rd = '0;
        if (eng.csel == SEL_L0) begin
            eng.cdata_rd = l0_mem[eng.caddr_rd];
        end else if ((eng.csel == SEL_L1) && rd_in_l1) begin
            eng.cdata_rd = l1_mem[eng.caddr_rd[L1_AW-1:0]];
        end
    end

    always_comb begin
        dump_word = '0;
        if (!dump_sel) begin
            dump_word = l0_mem[dump_addr];
        end else if (dump_in_l1) begin
            dump_word = l1_mem[dump_addr[L1_AW-1:0]];
        end
    end

    // ------------------------------------------------------------------
    // Memory arrays: never reset, contents survive reset and runs
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (img_wr_ok) begin
            img_mem[img_waddr] <= img_wdata;
        end
        if (wr_l0) begin
            l0_mem[eng.caddr_wr] <= eng.cdata_wr;
        end
        if (wr_l1) begin
            l1_mem[eng.caddr_wr[L1_AW-1:0]] <= eng.cdata_wr;
        end
    end

    // ------------------------------------------------------------------
    // Control state, handshake, flags and counters
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            eng.ready  <= 1'b0;
            busy_d     <= 1'b0;
            timer      <= '0;
            done       <= 1'b0;
            err        <= 4'b0000;
            l0_wr_cnt  <= '0;
            l1_wr_cnt  <= '0;
            dump_valid <= 1'b0;
            dump_data  <= '0;
        end else begin
            state     <= state_n;
            // ready is high for exactly the cycles spent in ARM
            eng.ready <= (state_n == ARM);
            busy_d    <= eng.busy;
            timer     <= (state == ARM) ? timer + TW'(1) : '0;

            dump_valid <= dump_ok;
            if (dump_ok) begin
                dump_data <= dump_word;
            end

            // a new run starts from clean flags and counts
            if (start_run) begin
                done      <= 1'b0;
                err       <= 4'b0000;
                l0_wr_cnt <= '0;
                l1_wr_cnt <= '0;
            end else begin
                if (timeout_hit || run_end) begin
                    done <= 1'b1;
                end
                err <= err | err_set;
                if (wr_l0 && (l0_wr_cnt != '1)) begin
                    l0_wr_cnt <= l0_wr_cnt + 13'd1;
                end
                if (wr_l1 && (l1_wr_cnt != '1)) begin
                    l1_wr_cnt <= l1_wr_cnt + 11'd1;
                end
            end
        end
    end

endmodule

// File: tb/tb_conv_host_mem.sv
// Self-checking bench for conv_host_mem: randomized engine traffic
// against a behavioural model of the image, L0 and L1 memories, the
// error flags and the write counters.
module tb_conv_host_mem;
    localparam int DW = 20;
    localparam int AW = 12;

    logic          clk = 1'b0;
    logic          reset;
    logic          start;
    logic          img_we;
    logic [AW-1:0] img_waddr;
    logic [DW-1:0] img_wdata;
    logic          dump_req;
    logic          dump_sel;
    logic [AW-1:0] dump_addr;
    logic [DW-1:0] dump_data;
    logic          dump_valid;
    logic          done;
    logic [3:0]    err;
    logic [12:0]   l0_wr_cnt;
    logic [10:0]   l1_wr_cnt;

    always #5 clk = ~clk;

    conv_host_if #(.DW(DW), .AW(AW)) bus ();

    conv_host_mem #(
        .DW(DW), .AW(AW), .L0_DEPTH(4096), .L1_DEPTH(1024), .RDY_TIMEOUT(16)
    ) dut (
        .clk(clk), .reset(reset), .eng(bus), .start(start),
        .img_we(img_we), .img_waddr(img_waddr), .img_wdata(img_wdata),
        .dump_req(dump_req), .dump_sel(dump_sel), .dump_addr(dump_addr),
        .dump_data(dump_data), .dump_valid(dump_valid), .done(done),
        .err(err), .l0_wr_cnt(l0_wr_cnt), .l1_wr_cnt(l1_wr_cnt)
    );

    // reference model
    logic [DW-1:0] img_m [4096];
    logic [DW-1:0] l0_m  [4096];
    logic [DW-1:0] l1_m  [1024];
    logic [3:0]    exp_err;
    int            exp_l0;
    int            exp_l1;

    int n_chk = 0;
    int n_err = 0;

    logic [AW-1:0] ra;
    logic [AW-1:0] rb;
    logic [DW-1:0] rd;
    logic [2:0]    rsel;
    logic [DW-1:0] exp_d;
    int            rc;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [DW-1:0] model_rd(input logic [2:0] sel, input logic [AW-1:0] a);
        if (sel == 3'b001) return l0_m[a];
        if (sel == 3'b011 && int'(a) < 1024) return l1_m[a[9:0]];
        return '0;
    endfunction

    task automatic model_clear_run();
        exp_err = 4'b0000;
        exp_l0  = 0;
        exp_l1  = 0;
    endtask

    // One engine bus cycle: optional check of cdata_rd before the edge,
    // then the model absorbs the write/read side effects.
    task automatic eng_cycle(input logic wr, input logic [2:0] sel, input logic [AW-1:0] aw,
                             input logic [DW-1:0] dw, input logic rdq, input logic [AW-1:0] ar,
                             input bit chk_rd);
        bus.cwr = wr; bus.csel = sel; bus.caddr_wr = aw; bus.cdata_wr = dw;
        bus.crd = rdq; bus.caddr_rd = ar;
        #1;
        if (chk_rd) check_eq("cdata_rd", bus.cdata_rd, model_rd(sel, ar));
        if (rdq) begin
            if (sel != 3'b001 && sel != 3'b011) exp_err[0] = 1'b1;
            else if (sel == 3'b011 && int'(ar) >= 1024) exp_err[1] = 1'b1;
        end
        if (wr) begin
            if (sel == 3'b001) begin
                l0_m[aw] = dw;
                if (exp_l0 < 8191) exp_l0++;
            end else if (sel == 3'b011) begin
                if (int'(aw) < 1024) begin
                    l1_m[aw[9:0]] = dw;
                    if (exp_l1 < 2047) exp_l1++;
                end else begin
                    exp_err[1] = 1'b1;
                end
            end else begin
                exp_err[0] = 1'b1;
            end
        end
        tick();
        bus.cwr = 1'b0;
        bus.crd = 1'b0;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        tick();
        start = 1'b0;
        model_clear_run();
    endtask

    task automatic check_status(input string tag);
        check_eq({tag, "_err"}, err, exp_err);
        check_eq({tag, "_l0cnt"}, l0_wr_cnt, exp_l0);
        check_eq({tag, "_l1cnt"}, l1_wr_cnt, exp_l1);
    endtask

    initial begin
        #3_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        reset = 1'b1; start = 1'b0; img_we = 1'b0; img_waddr = '0; img_wdata = '0;
        dump_req = 1'b0; dump_sel = 1'b0; dump_addr = '0;
        bus.busy = 1'b0; bus.iaddr = '0; bus.cwr = 1'b0; bus.caddr_wr = '0;
        bus.cdata_wr = '0; bus.crd = 1'b0; bus.caddr_rd = '0; bus.csel = 3'b000;
        model_clear_run();
        repeat (3) tick();
        reset = 1'b0;
        tick();

        // reset state
        check_eq("rst_ready", bus.ready, 1'b0);
        check_eq("rst_done", done, 1'b0);
        check_eq("rst_dump_valid", dump_valid, 1'b0);
        check_eq("rst_dump_data", dump_data, '0);
        check_status("rst");

        // image load: image[a] = a
        for (int a = 0; a < 4096; a++) begin
            img_we = 1'b1; img_waddr = a[AW-1:0]; img_wdata = DW'(a);
            img_m[a] = DW'(a);
            tick();
        end
        img_we = 1'b0;
        bus.iaddr = 12'h123;
        #1;
        check_eq("idata_123", bus.idata, 20'h00123);
        for (int k = 0; k < 8; k++) begin
            ra = AW'($urandom_range(0, 4095)); rd = DW'($urandom);
            img_we = 1'b1; img_waddr = ra; img_wdata = rd; img_m[ra] = rd;
            tick();
        end
        img_we = 1'b0;
        for (int k = 0; k < 16; k++) begin
            ra = AW'($urandom_range(0, 4095));
            bus.iaddr = ra;
            #1;
            check_eq("idata_rand", bus.idata, img_m[ra]);
        end

        // run 1: handshake, engine raises busy on the second ready cycle
        pulse_start();
        rc = 0;
        for (int c = 0; c < 40; c++) begin
            if (bus.ready) rc++;
            else if (rc > 0) break;
            if (rc == 2) bus.busy = 1'b1;
            tick();
        end
        check_eq("ready_len", rc, 2);
        check_eq("run_done_low", done, 1'b0);

        eng_cycle(1'b1, 3'b001, 12'd5, 20'hABCDE, 1'b0, '0, 1'b0);
        eng_cycle(1'b0, 3'b001, '0, '0, 1'b1, 12'd5, 1'b1);
        check_eq("rd_l0_5", bus.cdata_rd, 20'hABCDE);
        check_eq("l0cnt_one", l0_wr_cnt, 13'd1);

        // seed a window of L0/L1 so later reads have known contents
        for (int a = 0; a < 32; a++) begin
            eng_cycle(1'b1, 3'b001, AW'(a), DW'($urandom), 1'b0, '0, 1'b0);
            eng_cycle(1'b1, 3'b011, AW'(a), DW'($urandom), 1'b0, '0, 1'b0);
        end
        eng_cycle(1'b1, 3'b011, 12'd1024, 20'h5A5A5, 1'b0, '0, 1'b0);
        check_eq("err_l1_range", err, 4'b0010);
        eng_cycle(1'b0, 3'b011, '0, '0, 1'b0, 12'd0, 1'b1);
        eng_cycle(1'b1, 3'b010, 12'd7, 20'h11111, 1'b0, '0, 1'b0);
        check_eq("err_bad_sel", err, 4'b0011);
        check_status("seed");

        // randomized engine traffic
        for (int c = 0; c < 300; c++) begin
            rc = $urandom_range(0, 9);
            rsel = (rc < 4) ? 3'b001 : (rc < 8) ? 3'b011 : 3'($urandom_range(0, 7));
            ra = ($urandom_range(0, 7) == 0) ? AW'($urandom_range(1024, 4095)) : AW'($urandom_range(0, 31));
            rb = ($urandom_range(0, 7) == 0) ? AW'($urandom_range(1024, 4095)) : AW'($urandom_range(0, 31));
            if (rsel == 3'b001) begin
                ra = AW'($urandom_range(0, 31));
                rb = AW'($urandom_range(0, 31));
            end
            eng_cycle(1'($urandom_range(0, 1)), rsel, ra, DW'($urandom),
                      1'($urandom_range(0, 1)), rb, 1'b1);
        end
        check_status("rand");

        // image write and dump while running are refused and flagged
        ra = AW'($urandom_range(0, 4095));
        img_we = 1'b1; img_waddr = ra; img_wdata = ~img_m[ra];
        tick();
        img_we = 1'b0;
        exp_err[3] = 1'b1;
        bus.iaddr = ra;
        #1;
        check_eq("img_drop", bus.idata, img_m[ra]);
        check_eq("err_img_run", err, exp_err);
        dump_req = 1'b1; dump_sel = 1'b0; dump_addr = 12'd5;
        tick();
        dump_req = 1'b0;
        check_eq("dump_run_valid", dump_valid, 1'b0);

        // start is ignored in RUN
        start = 1'b1;
        tick();
        start = 1'b0;
        check_eq("start_ign_ready", bus.ready, 1'b0);
        check_status("start_ign");

        // busy falls -> done on the same edge
        bus.busy = 1'b0;
        tick();
        check_eq("fin_done", done, 1'b1);
        check_eq("fin_ready", bus.ready, 1'b0);
        check_status("fin");

        // back-to-back dumps in FIN
        for (int k = 0; k < 12; k++) begin
            ra = AW'($urandom_range(0, 31));
            dump_req = 1'b1; dump_sel = k[0]; dump_addr = ra;
            exp_d = k[0] ? l1_m[ra[9:0]] : l0_m[ra];
            tick();
            check_eq("dump_valid", dump_valid, 1'b1);
            check_eq("dump_data", dump_data, exp_d);
        end
        dump_req = 1'b0;
        tick();
        check_eq("dump_idle", dump_valid, 1'b0);

        // ready timeout
        pulse_start();
        check_eq("clr_done", done, 1'b0);
        check_status("clr");
        rc = 0;
        for (int c = 0; c < 40; c++) begin
            if (bus.ready) rc++;
            else if (rc > 0) break;
            tick();
        end
        check_eq("timeout_len", rc, 16);
        check_eq("timeout_err", err, 4'b0100);
        check_eq("timeout_done", done, 1'b1);
        check_eq("timeout_ready", bus.ready, 1'b0);

        // full run: every L0 and L1 word
        pulse_start();
        check_eq("full_arm_ready", bus.ready, 1'b1);
        bus.busy = 1'b1;
        tick();
        for (int a = 0; a < 4096; a++)
            eng_cycle(1'b1, 3'b001, AW'(a), DW'($urandom), 1'b0, '0, 1'b0);
        for (int a = 0; a < 1024; a++)
            eng_cycle(1'b1, 3'b011, AW'(a), DW'($urandom), 1'b0, 12'd0, 1'b1);
        check_eq("full_done_low", done, 1'b0);
        bus.busy = 1'b0;
        tick();
        check_eq("full_done", done, 1'b1);
        check_eq("full_l0cnt", l0_wr_cnt, 13'd4096);
        check_eq("full_l1cnt", l1_wr_cnt, 11'd1024);
        check_status("full");
        dump_req = 1'b1; dump_sel = 1'b1; dump_addr = 12'd1023;
        tick();
        dump_req = 1'b0;
        check_eq("dump_l1_valid", dump_valid, 1'b1);
        check_eq("dump_l1_1023", dump_data, l1_m[1023]);
        tick();
        check_eq("dump_l1_pulse", dump_valid, 1'b0);

        // reset in the middle of a run
        ra = AW'($urandom_range(0, 4095)); rd = DW'($urandom);
        img_we = 1'b1; img_waddr = ra; img_wdata = rd; img_m[ra] = rd;
        tick();
        img_we = 1'b0;
        pulse_start();
        bus.busy = 1'b1;
        tick();
        for (int k = 0; k < 3; k++)
            eng_cycle(1'b1, 3'b001, AW'($urandom_range(0, 4095)), DW'($urandom), 1'b0, '0, 1'b0);
        check_eq("pre_rst_l0cnt", l0_wr_cnt, 13'd3);
        reset = 1'b1;
        tick();
        model_clear_run();
        check_eq("mid_rst_ready", bus.ready, 1'b0);
        check_eq("mid_rst_done", done, 1'b0);
        check_status("mid_rst");
        reset = 1'b0; bus.busy = 1'b0;
        bus.iaddr = ra;
        #1;
        check_eq("img_kept", bus.idata, img_m[ra]);
        rb = AW'($urandom_range(0, 4095));
        dump_req = 1'b1; dump_sel = 1'b0; dump_addr = rb;
        tick();
        dump_req = 1'b0;
        check_eq("l0_kept", dump_data, l0_m[rb]);
        tick();
        check_eq("post_rst_done", done, 1'b0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule
